// File: rtl/l1_port_arbiter_if.sv
// Requester, response and L1-side signal bundle for l1_port_arbiter.
// The arbiter connects through the slave modport; the requesters/L1 model use master.
interface l1_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              resp0_valid;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              resp1_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_en;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    modport slave (
        input  req0_valid, req0_addr, req1_valid, req1_addr, mem_data, mem_ready,
        output req0_ready, resp0_valid, req1_ready, resp1_valid,
               resp_data, resp_err, mem_addr, mem_en
    );

    modport master (
        output req0_valid, req0_addr, req1_valid, req1_addr, mem_data, mem_ready,
        input  req0_ready, resp0_valid, req1_ready, resp1_valid,
               resp_data, resp_err, mem_addr, mem_en
    );
endinterface

// File: rtl/l1_port_arbiter.sv
// Two-port read arbiter in front of the single-port L1: port 0 has priority, port 1 is
// forced through after STARVE_MAX back-to-back port 0 wins. `L1_ARB_TIMEOUT_EN adds a WAIT-state timeout.
module l1_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input logic              clk,
    input logic              rst,
    l1_port_arbiter_if.slave bus
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("STARVE_MAX out of range 1..15");
    end
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range 2..255");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp0_valid_q, resp0_valid_d;
    logic              resp1_valid_q, resp1_valid_d;
    logic              any_req;
    logic              grant1;
    logic              timeout_hit;

    assign any_req = bus.req0_valid | bus.req1_valid;
    assign grant1  = bus.req1_valid & (~bus.req0_valid | (starve_cnt_q == STARVE_LIM));

`ifdef L1_ARB_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       resp_err_q, resp_err_d;

    // mem_ready on the final WAIT cycle takes precedence over the abort
    assign timeout_hit = (state_q == WAIT) & ~bus.mem_ready & (wait_cnt_q == WAIT_LAST);
    assign wait_cnt_d  = (state_q == WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
    assign resp_err_d  = timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign bus.resp_err = resp_err_q;
`else
    assign timeout_hit  = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.mem_ready || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d       = owner_q;
        starve_cnt_d  = starve_cnt_q;
        mem_addr_d    = mem_addr_q;
        resp_data_d   = resp_data_q;
        resp0_valid_d = 1'b0;
        resp1_valid_d = 1'b0;
        if (state_q == IDLE && any_req) begin
            owner_d    = grant1;
            mem_addr_d = grant1 ? bus.req1_addr : bus.req0_addr;
            if (grant1 || !bus.req1_valid) begin
                starve_cnt_d = 4'd0;
            end else if (starve_cnt_q != STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
        if (state_q == WAIT && (bus.mem_ready || timeout_hit)) begin
            resp_data_d   = bus.mem_ready ? bus.mem_data : '0;
            resp0_valid_d = ~owner_q;
            resp1_valid_d = owner_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q       <= 1'b0;
            starve_cnt_q  <= '0;
            mem_addr_q    <= '0;
            resp_data_q   <= '0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            owner_q       <= owner_d;
            starve_cnt_q  <= starve_cnt_d;
            mem_addr_q    <= mem_addr_d;
            resp_data_q   <= resp_data_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    // Ready and mem_en decode straight from state so an async reset clears them at once
    always_comb begin
        bus.mem_en      = (state_q == ISSUE);
        bus.req0_ready  = (state_q == ISSUE) & ~owner_q;
        bus.req1_ready  = (state_q == ISSUE) & owner_q;
        bus.resp0_valid = resp0_valid_q;
        bus.resp1_valid = resp1_valid_q;
        bus.resp_data   = resp_data_q;
        bus.mem_addr    = mem_addr_q;
    end

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Scoreboard bench for l1_port_arbiter: expected grants/responses are queued as requests
// are driven and retired by a negedge monitor. Timeout checks follow `L1_ARB_TIMEOUT_EN.
module tb_l1_port_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    l1_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    l1_port_arbiter #(
        .ADDR_W(16), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        port;
        logic [15:0] addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   mem_en_cnt = 0;
    logic mem_en_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // L1 contents model: one known word, everything else derived from the address
    function automatic logic [31:0] l1_word(input logic [15:0] a);
        return (a == 16'h0005) ? 32'hDEADBEEF : {~a, a};
    endfunction

    assign bus.mem_data = l1_word(bus.mem_addr);

    task automatic push_exp(input logic port, input logic [15:0] addr, input logic err);
        exp_t e;
        e.port = port;
        e.addr = addr;
        e.err  = err;
        e.data = err ? 32'h0 : l1_word(addr);
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mem_en_prev = 1'b0;
        end else begin
            check("excl_ready", bus.req0_ready & bus.req1_ready, 0);
            check("excl_resp", bus.resp0_valid & bus.resp1_valid, 0);
            if (bus.mem_en) begin
                mem_en_cnt++;
                check("mem_en_1cyc", mem_en_prev, 0);
                check("issue_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check("mem_addr", bus.mem_addr, sb_q[0].addr);
            end
            if (bus.req0_ready || bus.req1_ready) begin
                check("ready_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) check("grant_port", bus.req1_ready, sb_q[0].port);
            end
            if (bus.resp0_valid || bus.resp1_valid) begin
                check("resp_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("resp_port", bus.resp1_valid, mon_e.port);
                    check("resp_data", bus.resp_data, mon_e.data);
                    check("resp_err", bus.resp_err, mon_e.err);
                    $display("resp port=%0d addr=0x%04h data=0x%08h err=%0d",
                             bus.resp1_valid, mon_e.addr, bus.resp_data, bus.resp_err);
                end
            end
            mem_en_prev = bus.mem_en;
        end
    end

    task automatic wait_any_ready(output int port);
        port = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin port = 0; break; end
            if (bus.req1_ready) begin port = 1; break; end
        end
        check("ready_seen", port != -1, 1);
    endtask

    task automatic wait_ready(input int want);
        int p;
        wait_any_ready(p);
        check("ready_port", p, want);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int cnt;
        int en_before;
        int pattern[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_addr = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0;
        bus.mem_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {bus.req0_ready, bus.req1_ready, bus.resp0_valid,
                           bus.resp1_valid, bus.resp_err, bus.mem_en}, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_resp_data", bus.resp_data, 0);
        rst = 1'b0;

        // Single port 1 read, exact latency
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0005;
        push_exp(1'b1, 16'h0005, 1'b0);
        @(negedge clk);
        check("t1_req1_ready", bus.req1_ready, 1);
        check("t1_mem_en", bus.mem_en, 1);
        check("t1_mem_addr", bus.mem_addr, 16'h0005);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("t1_ready_drop", {bus.req1_ready, bus.mem_en, bus.resp1_valid}, 0);
        @(negedge clk);
        check("t1_resp1_valid", bus.resp1_valid, 1);
        check("t1_resp_data", bus.resp_data, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("t1_hold_data", bus.resp_data, 32'hDEADBEEF);
        check("t1_resp_pulse", bus.resp1_valid, 0);

        // Both ports held valid: starvation counter forces every fifth grant to port 1
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0100;
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0200;
        foreach (pattern[g]) push_exp(pattern[g][0], pattern[g] != 0 ? 16'h0200 : 16'h0100, 1'b0);
        foreach (pattern[g]) begin
            wait_any_ready(p);
            check("starve_seq", p, pattern[g]);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        drain();

        // Five-cycle L1 stall
        bus.mem_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0300;
        push_exp(1'b0, 16'h0300, 1'b0);
        en_before = mem_en_cnt;
        wait_ready(0);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_resp", bus.resp0_valid | bus.resp1_valid, 0);
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("stall_resp0", bus.resp0_valid, 1);
        check("stall_mem_en_cnt", mem_en_cnt - en_before, 1);
        drain();

        // Asynchronous reset during WAIT drops the transaction
        bus.mem_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0400;
        push_exp(1'b0, 16'h0400, 1'b0);
        wait_ready(0);
        bus.req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check("arst_ctrl", {bus.req0_ready, bus.req1_ready, bus.resp0_valid,
                            bus.resp1_valid, bus.resp_err, bus.mem_en}, 0);
        check("arst_mem_addr", bus.mem_addr, 0);
        check("arst_resp_data", bus.resp_data, 0);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_resp", bus.resp0_valid | bus.resp1_valid, 0);
        end
        // Counter restarts at zero: four port 0 grants before the forced port 1 grant
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0410;
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0500;
        for (int g = 0; g < 5; g++) push_exp(g == 4, g == 4 ? 16'h0500 : 16'h0410, 1'b0);
        for (int g = 0; g < 5; g++) begin
            wait_any_ready(p);
            check("arst_starve_seq", p, (g == 4) ? 1 : 0);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        drain();

        // Port 0 pulses during a port 1 ISSUE and withdraws before IDLE
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0600;
        push_exp(1'b1, 16'h0600, 1'b0);
        wait_ready(1);
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0666;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.req0_ready) cnt++;
        end
        check("drop_no_req0_ready", cnt, 0);
        drain();

        // L1 never answers
        bus.mem_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0700;
`ifdef L1_ARB_TIMEOUT_EN
        push_exp(1'b0, 16'h0700, 1'b1);
        wait_ready(0);
        bus.req0_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            check("to_early_resp", bus.resp0_valid, 0);
        end
        @(negedge clk);
        check("to_resp0_valid", bus.resp0_valid, 1);
        check("to_resp_err", bus.resp_err, 1);
        check("to_resp_data", bus.resp_data, 0);
        bus.mem_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0800;
        push_exp(1'b1, 16'h0800, 1'b0);
        wait_ready(1);
        bus.req1_valid = 1'b0;
        drain();
`else
        push_exp(1'b0, 16'h0700, 1'b0);
        wait_ready(0);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i % 10 == 9) begin
                check("nto_no_resp", bus.resp0_valid | bus.resp1_valid, 0);
                check("nto_resp_err", bus.resp_err, 0);
            end
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        check("nto_late_resp0", bus.resp0_valid, 1);
        drain();
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
